// File: rtl/async_fifo_pkg.sv
// Shared types and constants for the async_fifo read-side blocks.
package async_fifo_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_e;

  localparam int SKID_DEPTH         = 2;
  localparam int SKID_CNT_WIDTH     = $clog2(SKID_DEPTH + 1);
  localparam int DEF_RD_WIDTH       = 32;
  localparam int DEF_RD_CNT_WIDTH   = 6;
  localparam int DEF_BEAT_CNT_WIDTH = 16;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry single-clock register FIFO; entry0 is always the head.
module fifo_skid_buf
  import async_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_RD_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  output logic [SKID_CNT_WIDTH-1:0] cnt,
  output logic [WIDTH-1:0]          head_data
);

  logic [WIDTH-1:0] entry0;
  logic [WIDTH-1:0] entry1;

  // Callers never pop when empty nor push when full without a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      entry0 <= '0;
      entry1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == '0) entry0 <= push_data;
          else           entry1 <= push_data;
          cnt <= cnt + 1'b1;
        end
        2'b01: begin
          entry0 <= entry1;
          cnt    <= cnt - 1'b1;
        end
        2'b11: begin
          if (cnt == SKID_CNT_WIDTH'(1)) begin
            entry0 <= push_data;
          end else begin
            entry0 <= entry1;
            entry1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_data = entry0;

endmodule

// File: rtl/async_fifo_rd_stream.sv
// Drains the async_fifo read port into a valid/ready stream through a 2-entry skid buffer.
// Optional start threshold enabled by defining ASYNC_FIFO_RD_THRESH_EN.
//   state  | meaning
//   IDLE   | no reads issued; waiting for start condition
//   STREAM | reads issued whenever credit allows
module async_fifo_rd_stream
  import async_fifo_pkg::*;
#(
  parameter int RD_WIDTH       = DEF_RD_WIDTH,
  parameter int RD_CNT_WIDTH   = DEF_RD_CNT_WIDTH,
  parameter int START_THRESH   = 8,
  parameter int BEAT_CNT_WIDTH = DEF_BEAT_CNT_WIDTH
) (
  input  logic                      rd_clk,
  input  logic                      rd_rst_n,
  input  logic                      fifo_empty,
  input  logic [RD_CNT_WIDTH-1:0]   rd_data_count,
  input  logic [RD_WIDTH-1:0]       rd_data,
  output logic                      rd_en,
  input  logic                      flush,
  input  logic                      m_ready,
  output logic                      m_valid,
  output logic [RD_WIDTH-1:0]       m_data,
  output logic [BEAT_CNT_WIDTH-1:0] beat_cnt
);

  localparam logic [RD_CNT_WIDTH-1:0] START_LVL = RD_CNT_WIDTH'(START_THRESH);

  rd_state_e                 state;
  logic                      inflight;
  logic                      pop;
  logic                      start;
  logic [SKID_CNT_WIDTH-1:0] buf_cnt;
  logic [SKID_CNT_WIDTH:0]   credit_used;

`ifdef ASYNC_FIFO_RD_THRESH_EN
  assign start = (rd_data_count >= START_LVL) || flush;
`else
  logic unused_cfg;
  assign unused_cfg = ^{flush, rd_data_count, START_LVL};
  assign start      = !fifo_empty;
`endif

  assign pop = m_valid && m_ready;

  // Words already owned (buffered or in flight) after this cycle's pop; pop implies buf_cnt >= 1.
  assign credit_used = {1'b0, buf_cnt} + (SKID_CNT_WIDTH + 1)'(inflight)
                     - (SKID_CNT_WIDTH + 1)'(pop);
  assign rd_en = (state == STREAM) && !fifo_empty
              && (credit_used < (SKID_CNT_WIDTH + 1)'(SKID_DEPTH));

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state    <= IDLE;
      inflight <= 1'b0;
      beat_cnt <= '0;
    end else begin
      inflight <= rd_en;
      if (pop) beat_cnt <= beat_cnt + 1'b1;
      case (state)
        IDLE:    if (start) state <= STREAM;
        STREAM:  if (fifo_empty && !inflight && (buf_cnt == '0) && !start) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  fifo_skid_buf #(.WIDTH(RD_WIDTH)) u_skid (
    .clk       (rd_clk),
    .rst_n     (rd_rst_n),
    .push      (inflight),
    .push_data (rd_data),
    .pop       (pop),
    .cnt       (buf_cnt),
    .head_data (m_data)
  );

  assign m_valid = (buf_cnt != '0);

endmodule
